// File: rtl/encap_tunnel_lookup_ctrl.sv
// Tunnel lookup sequencer: parallel bucket read from two hash tables, key compare, value fetch, tagged response.
// Optional statistics counters are enabled with `define ENCAP_TUNNEL_LOOKUP_STATS_EN.
module encap_tunnel_lookup_ctrl #(
    parameter int DEPTH_NBITS       = 10,
    parameter int BUCKET_NBITS      = 64,
    parameter int KEY_NBITS         = 32,
    parameter int VALUE_DEPTH_NBITS = 10,
    parameter int VALUE_NBITS       = 352,
    parameter int ID_NBITS          = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lkup_req,
    output logic                         lkup_ready,
    input  logic [KEY_NBITS-1:0]         lkup_key,
    input  logic [DEPTH_NBITS-1:0]       lkup_hash0,
    input  logic [DEPTH_NBITS-1:0]       lkup_hash1,
    input  logic [ID_NBITS-1:0]          lkup_id,
    output logic                         tunnel_hash_table0_rd,
    output logic [DEPTH_NBITS-1:0]       tunnel_hash_table0_raddr,
    input  logic                         tunnel_hash_table0_ack,
    input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table0_rdata,
    output logic                         tunnel_hash_table1_rd,
    output logic [DEPTH_NBITS-1:0]       tunnel_hash_table1_raddr,
    input  logic                         tunnel_hash_table1_ack,
    input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table1_rdata,
    output logic                         tunnel_value_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] tunnel_value_raddr,
    input  logic                         tunnel_value_ack,
    input  logic [VALUE_NBITS-1:0]       tunnel_value_rdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_hit,
    output logic                         rsp_dup,
    output logic [ID_NBITS-1:0]          rsp_id,
    output logic [VALUE_NBITS-1:0]       rsp_value
`ifdef ENCAP_TUNNEL_LOOKUP_STATS_EN
    ,
    input  logic                         stat_clr,
    output logic [31:0]                  stat_hit_cnt,
    output logic [31:0]                  stat_miss_cnt,
    output logic [31:0]                  stat_dup_cnt
`endif
);

    localparam int VALID_BIT = KEY_NBITS + VALUE_DEPTH_NBITS;

    typedef enum logic [2:0] {IDLE, HT_RD, HT_WAIT, CMP, VAL_RD, VAL_WAIT, RSP} state_t;

    state_t state_reg, state_next;

    logic [KEY_NBITS-1:0]         key_reg;
    logic [DEPTH_NBITS-1:0]       hash0_reg, hash1_reg;
    logic [ID_NBITS-1:0]          id_reg;
    logic                         hit_reg, dup_reg;
    logic [VALUE_DEPTH_NBITS-1:0] vptr_reg;
    logic [VALUE_NBITS-1:0]       value_reg;

    logic [1:0]                          ht_ack;
    logic [1:0][VALID_BIT:0]             ht_rdata;
    logic [1:0]                          got, hit;
    logic [1:0][VALUE_DEPTH_NBITS-1:0]   vptr;

    assign ht_ack      = {tunnel_hash_table1_ack, tunnel_hash_table0_ack};
    assign ht_rdata[0] = tunnel_hash_table0_rdata[VALID_BIT:0];
    assign ht_rdata[1] = tunnel_hash_table1_rdata[VALID_BIT:0];

    // Per-table capture: only the first ack in HT_WAIT is kept; stray acks elsewhere are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_table
            logic [VALID_BIT:0] bucket_reg;
            logic               got_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bucket_reg <= '0;
                    got_reg    <= 1'b0;
                end else if (state_reg == HT_RD) begin
                    got_reg <= 1'b0;
                end else if (state_reg == HT_WAIT && ht_ack[gi] && !got_reg) begin
                    bucket_reg <= ht_rdata[gi];
                    got_reg    <= 1'b1;
                end
            end

            assign got[gi]  = got_reg;
            assign hit[gi]  = bucket_reg[VALID_BIT] &&
                              (bucket_reg[VALID_BIT-1:VALUE_DEPTH_NBITS] == key_reg);
            assign vptr[gi] = bucket_reg[VALUE_DEPTH_NBITS-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next            = state_reg;
        lkup_ready            = 1'b0;
        tunnel_hash_table0_rd = 1'b0;
        tunnel_hash_table1_rd = 1'b0;
        tunnel_value_rd       = 1'b0;
        rsp_valid             = 1'b0;
        case (state_reg)
            IDLE: begin
                lkup_ready = 1'b1;
                if (lkup_req) state_next = HT_RD;
            end
            HT_RD: begin
                tunnel_hash_table0_rd = 1'b1;
                tunnel_hash_table1_rd = 1'b1;
                state_next            = HT_WAIT;
            end
            HT_WAIT: if (&got) state_next = CMP;
            CMP:     state_next = (|hit) ? VAL_RD : RSP;
            VAL_RD: begin
                tunnel_value_rd = 1'b1;
                state_next      = VAL_WAIT;
            end
            VAL_WAIT: if (tunnel_value_ack) state_next = RSP;
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg   <= '0;
            hash0_reg <= '0;
            hash1_reg <= '0;
            id_reg    <= '0;
            hit_reg   <= 1'b0;
            dup_reg   <= 1'b0;
            vptr_reg  <= '0;
            value_reg <= '0;
        end else begin
            if (state_reg == IDLE && lkup_req) begin
                key_reg   <= lkup_key;
                hash0_reg <= lkup_hash0;
                hash1_reg <= lkup_hash1;
                id_reg    <= lkup_id;
            end
            // Table 0 takes priority on a double hit.
            if (state_reg == CMP) begin
                hit_reg  <= |hit;
                dup_reg  <= &hit;
                vptr_reg <= hit[0] ? vptr[0] : vptr[1];
                if (!(|hit)) value_reg <= '0;
            end
            if (state_reg == VAL_WAIT && tunnel_value_ack) value_reg <= tunnel_value_rdata;
        end
    end

    assign tunnel_hash_table0_raddr = hash0_reg;
    assign tunnel_hash_table1_raddr = hash1_reg;
    assign tunnel_value_raddr       = vptr_reg;
    assign rsp_hit                  = hit_reg;
    assign rsp_dup                  = dup_reg;
    assign rsp_id                   = id_reg;
    assign rsp_value                = value_reg;

`ifdef ENCAP_TUNNEL_LOOKUP_STATS_EN
    logic        rsp_fire;
    logic [31:0] hit_cnt_reg, miss_cnt_reg, dup_cnt_reg;

    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || stat_clr) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            dup_cnt_reg  <= '0;
        end else if (rsp_fire) begin
            if (hit_reg && hit_cnt_reg != 32'hFFFF_FFFF)   hit_cnt_reg  <= hit_cnt_reg + 32'd1;
            if (!hit_reg && miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
            if (dup_reg && dup_cnt_reg != 32'hFFFF_FFFF)   dup_cnt_reg  <= dup_cnt_reg + 32'd1;
        end
    end

    assign stat_hit_cnt  = hit_cnt_reg;
    assign stat_miss_cnt = miss_cnt_reg;
    assign stat_dup_cnt  = dup_cnt_reg;
`endif

endmodule
